// File: rtl/pixel_seq_ctrl_pkg.sv
// Shared types and defaults for the pixel frame sequencer (package pixseq_pkg).
package pixseq_pkg;

  localparam int NPIX_D      = 4;
  localparam int DW_D        = 8;
  localparam int EW_D        = 16;
  localparam int ERASE_CYC_D = 5;

  typedef enum logic [2:0] {
    IDLE, ERASE, EXPOSE, CONVERT, READ_DRV, READ_OUT, DONE
  } state_t;

  // index width that stays legal for a single-pixel array
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_seq_ctrl_if.sv
// Sample stream from the sequencer to frame storage: valid/ready with pixel index tag.
interface pixel_seq_ctrl_if #(
  parameter int DW = 8,
  parameter int IW = 2
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [IW-1:0] idx;

  modport master (output valid, data, idx, input ready);
  modport slave  (input valid, data, idx, output ready);
endinterface

// File: rtl/pixel_seq_ctrl_down_cnt.sv
// Loadable down-counter with zero flag (module pixseq_down_cnt); times ERASE and EXPOSE.
module pixseq_down_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] ld_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  // load wins over decrement so a phase can be re-armed on its last cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= ld_val;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/pixel_seq_ctrl.sv
// Frame sequencer for the shared-bus pixel array: erase, expose, ramp conversion,
// then per-pixel readout onto a valid/ready stream.
// Optional: define PIXSEQ_CONTINUOUS_EN to add the cont input for back-to-back frames.
module pixel_seq_ctrl
  import pixseq_pkg::*;
#(
  parameter int NPIX      = NPIX_D,
  parameter int DW        = DW_D,
  parameter int EW        = EW_D,
  parameter int ERASE_CYC = ERASE_CYC_D
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [EW-1:0]   exp_cycles,
  input  logic [DW-1:0]   pix_data,
`ifdef PIXSEQ_CONTINUOUS_EN
  input  logic            cont,
`endif
  output logic            erase,
  output logic            expose,
  output logic            convert,
  output logic [DW-1:0]   ramp_code,
  output logic [NPIX-1:0] read,
  output logic            busy,
  output logic            frame_done,
  pixel_seq_ctrl_if.master os
);
  localparam int IW = idx_w(NPIX);

  state_t        state;
  logic [IW-1:0] idx;
  logic [EW-1:0] exp_lat;
  logic          cnt_load, cnt_dec, cnt_zero, cont_go;
  logic [EW-1:0] cnt_ld_val;

`ifdef PIXSEQ_CONTINUOUS_EN
  assign cont_go = cont;
`else
  assign cont_go = 1'b0;
`endif

  // phase timer: armed with ERASE_CYC-1 before ERASE, re-armed with exp-1 when ERASE ends
  always_comb begin
    cnt_load   = (state == IDLE) || (state == DONE) || ((state == ERASE) && cnt_zero);
    cnt_dec    = (state == ERASE) || (state == EXPOSE);
    cnt_ld_val = (state == ERASE) ? (exp_lat - EW'(1)) : EW'(ERASE_CYC - 1);
  end

  pixseq_down_cnt #(.W(EW)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (cnt_load),
    .dec    (cnt_dec),
    .ld_val (cnt_ld_val),
    .zero   (cnt_zero)
  );

  // sequencer FSM; every output is set on the edge that enters the state it belongs to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      exp_lat    <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      ramp_code  <= '0;
      read       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      os.valid   <= 1'b0;
      os.data    <= '0;
      os.idx     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          exp_lat <= (exp_cycles == '0) ? EW'(1) : exp_cycles;
          erase   <= 1'b1;
          busy    <= 1'b1;
          state   <= ERASE;
        end
        ERASE: if (cnt_zero) begin
          erase  <= 1'b0;
          expose <= 1'b1;
          state  <= EXPOSE;
        end
        EXPOSE: if (cnt_zero) begin
          expose    <= 1'b0;
          convert   <= 1'b1;
          ramp_code <= '0;
          state     <= CONVERT;
        end
        CONVERT: begin
          if (&ramp_code) begin
            convert   <= 1'b0;
            ramp_code <= '0;
            idx       <= '0;
            read      <= '0;
            read[0]   <= 1'b1;
            state     <= READ_DRV;
          end else begin
            ramp_code <= ramp_code + 1'b1;
          end
        end
        READ_DRV: begin
          read     <= '0;
          os.data  <= pix_data;
          os.idx   <= idx;
          os.valid <= 1'b1;
          state    <= READ_OUT;
        end
        READ_OUT: if (os.ready) begin
          os.valid <= 1'b0;
          if (idx == IW'(NPIX - 1)) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            idx              <= idx + 1'b1;
            read[idx + 1'b1] <= 1'b1;
            state            <= READ_DRV;
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          if (cont_go) begin
            erase <= 1'b1;
            state <= ERASE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Self-checking bench for pixel_seq_ctrl: timeline reference model per frame.
module tb_pixel_seq_ctrl;
  localparam int NPIX = 4, DW = 8, EW = 16, EC = 5, IW = 2, CONV = 1 << DW;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [EW-1:0]   exp_cycles;
  logic [DW-1:0]   pix_data;
  logic            erase, expose, convert, busy, frame_done;
  logic [DW-1:0]   ramp_code;
  logic [NPIX-1:0] read;
`ifdef PIXSEQ_CONTINUOUS_EN
  logic            cont;
`endif
  logic [DW-1:0]   pix [NPIX];
  int n_cmp = 0, n_err = 0;

  pixel_seq_ctrl_if #(.DW(DW), .IW(IW)) os ();

  pixel_seq_ctrl #(.NPIX(NPIX), .DW(DW), .EW(EW), .ERASE_CYC(EC)) dut (
    .clk(clk), .reset(reset), .start(start), .exp_cycles(exp_cycles), .pix_data(pix_data),
`ifdef PIXSEQ_CONTINUOUS_EN
    .cont(cont),
`endif
    .erase(erase), .expose(expose), .convert(convert), .ramp_code(ramp_code), .read(read),
    .busy(busy), .frame_done(frame_done), .os(os)
  );

  always #5 clk = ~clk;

  // pixel array model: the selected pixel drives the shared bus
  always_comb begin
    pix_data = '0;
    for (int i = 0; i < NPIX; i++) if (read[i]) pix_data = pix[i];
  end

  // one frame from the reference timeline; rmode 0 ready high, 1 stall idx1 for 20, 2 random
  task automatic run_frame(input int e, input int rmode, input bit do_start, input bit poke);
    int e_eff, t_conv, t_rd, total, pos, stall, guard, nhs, r, ix;
    logic e_er, e_ex, e_cv, e_vd, e_dn;
    logic [DW-1:0] e_rp;
    logic [NPIX-1:0] e_rd;
    logic [17:0] ev, av;
    e_eff = (e == 0) ? 1 : e;
    t_conv = EC + e_eff; t_rd = t_conv + CONV; total = t_rd + 2 * NPIX + 1;
    pos = 1; stall = 0; guard = 0; nhs = 0; ix = 0;
    @(negedge clk);
    if (do_start) begin
      n_cmp++;
      if ({erase, expose, convert, ramp_code, read, busy, frame_done, os.valid} !== '0) begin
        n_err++; $display("FAIL idle_before_start: got %b want 0",
          {erase, expose, convert, ramp_code, read, busy, frame_done, os.valid});
      end
      start = 1'b1; exp_cycles = EW'(e);
      @(negedge clk);
      start = 1'b0;
    end
    while (1) begin
      e_er = 0; e_ex = 0; e_cv = 0; e_vd = 0; e_dn = 0; e_rp = '0; e_rd = '0;
      if (pos <= EC) e_er = 1;
      else if (pos <= t_conv) e_ex = 1;
      else if (pos <= t_rd) begin e_cv = 1; e_rp = DW'(pos - t_conv - 1); end
      else if (pos < total) begin
        r = pos - t_rd - 1; ix = r / 2;
        if (r % 2 == 0) e_rd = NPIX'(1) << ix;
        else e_vd = 1;
      end else e_dn = 1;
      case (rmode)
        0: os.ready = 1'b1;
        1: if (e_vd && ix == 1 && stall < 20) begin os.ready = 1'b0; stall++; end
           else os.ready = 1'b1;
        default: os.ready = 1'($urandom_range(0, 1));
      endcase
      start = poke && (pos == t_conv + 10);
      ev = {e_er, e_ex, e_cv, e_rp, e_rd, 1'b1, e_dn, e_vd};
      av = {erase, expose, convert, ramp_code, read, busy, frame_done, os.valid};
      n_cmp++;
      if (av !== ev) begin
        n_err++; $display("FAIL strobes@pos%0d: got %b want %b", pos, av, ev);
      end
      if (e_vd) begin
        n_cmp++;
        if ({os.idx, os.data} !== {IW'(ix), pix[ix]}) begin
          n_err++; $display("FAIL sample@pos%0d: got idx %0d data %h want idx %0d data %h",
            pos, os.idx, os.data, ix, pix[ix]);
        end
        if (os.ready) nhs++;
      end
      if (pos == total) break;
      if (!(e_vd && !os.ready)) pos++;
      guard++;
      if (guard > 5000) begin
        n_err++; $display("FAIL frame_timeout: got no frame_done want done by pos %0d", total);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (nhs !== NPIX) begin
      n_err++; $display("FAIL sample_count: got %0d want %0d", nhs, NPIX);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; exp_cycles = '0; os.ready = 1'b0;
`ifdef PIXSEQ_CONTINUOUS_EN
    cont = 1'b0;
`endif
    pix[0] = 8'h11; pix[1] = 8'h22; pix[2] = 8'h33; pix[3] = 8'h44;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({erase, expose, convert, ramp_code, read, busy, frame_done, os.valid, os.data, os.idx} !== '0) begin
      n_err++; $display("FAIL reset_state: got %b want 0",
        {erase, expose, convert, ramp_code, read, busy, frame_done, os.valid, os.data, os.idx});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_frame(10, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    run_frame(int'($urandom_range(1, 30)), 1, 1, 0);
  endtask

  task automatic test_exp_zero_ignored_start();
    bit bad;
    run_frame(0, 0, 1, 1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || erase !== 1'b0) bad = 1;
    end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL no_second_frame: got busy/erase high want idle"); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NPIX; i++) pix[i] = DW'($urandom);
      run_frame(int'($urandom_range(0, 40)), 2, 1, 0);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    pix[0] = 8'h11; pix[1] = 8'h22; pix[2] = 8'h33; pix[3] = 8'h44;
    @(negedge clk);
    start = 1'b1; exp_cycles = EW'(3);
    @(negedge clk);
    start = 1'b0; g = 0;
    while (ramp_code !== DW'(100) && g < 1000) begin @(negedge clk); g++; end
    n_cmp++;
    if (g !== EC + 3 + 100) begin
      n_err++; $display("FAIL ramp100_time: got %0d want %0d", g, EC + 3 + 100);
    end
    n_cmp++;
    if (convert !== 1'b1) begin n_err++; $display("FAIL convert_before_reset: got %b want 1", convert); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({convert, ramp_code, busy} !== '0) begin
      n_err++; $display("FAIL async_reset: got %b want 0", {convert, ramp_code, busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({erase, expose, convert, read, os.valid, frame_done} !== '0) begin
      n_err++; $display("FAIL reset_hold: got %b want 0", {erase, expose, convert, read, os.valid, frame_done});
    end
    reset = 1'b0;
    run_frame(5, 0, 1, 0);
  endtask

`ifdef PIXSEQ_CONTINUOUS_EN
  task automatic test_continuous();
    int e;
    e = int'($urandom_range(1, 20));
    cont = 1'b1;
    run_frame(e, 0, 1, 0);
    @(posedge clk);
    #1 cont = 1'b0;
    run_frame(e, 2, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_exp_zero_ignored_start();
    test_random();
    test_reset_mid();
`ifdef PIXSEQ_CONTINUOUS_EN
    test_continuous();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
